// File: rtl/alu_arb.sv
// Two-requester round-robin front end sharing one pipelined ALU.
// Results return two cycles after the grant, tagged by a {valid, id} shift register.

module alu (
  input  logic       ck,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] CTR,
  output logic [7:0] O
);

  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [3:0] ctr_r;
  logic [7:0] o_r;
  logic [7:0] res_s;

  // Operand capture and result register; neither is reset, the caller gates validity.
  always_ff @(posedge ck) begin
    a_r   <= A;
    b_r   <= B;
    ctr_r <= CTR;
    o_r   <= res_s;
  end

  // Operation decode; unused opcodes yield zero.
  always_comb begin
    res_s = 8'h00;
    case (ctr_r)
      4'b0000: res_s = a_r + b_r;
      4'b0001: res_s = a_r - b_r;
      4'b1000: res_s = a_r & b_r;
      4'b1001: res_s = a_r | b_r;
      4'b1010: res_s = a_r ^ b_r;
      4'b1011: res_s = ~a_r;
      4'b1100: res_s = {1'b0, a_r[7:1]};
      4'b1101: res_s = {a_r[6:0], 1'b0};
      4'b1110: res_s = {a_r[0], a_r[7:1]};
      4'b1111: res_s = {a_r[6:0], a_r[7]};
      default: res_s = 8'h00;
    endcase
  end

  assign O = o_r;

endmodule

module alu_arb #(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             req0,
  input  logic [7:0]       a0,
  input  logic [7:0]       b0,
  input  logic [3:0]       ctr0,
  input  logic             req1,
  input  logic [7:0]       a1,
  input  logic [7:0]       b1,
  input  logic [3:0]       ctr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [7:0]       res,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [CNT_W-1:0] done0,
  output logic [CNT_W-1:0] done1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             ptr_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic [7:0]       alu_a_s;
  logic [7:0]       alu_b_s;
  logic [3:0]       alu_ctr_s;
  logic             s1_valid_r;
  logic             s1_id_r;
  logic             s2_valid_r;
  logic             s2_id_r;
  logic [CNT_W-1:0] done0_r;
  logic [CNT_W-1:0] done1_r;
  logic [7:0]       alu_o_s;

  // Round-robin grant; ptr only breaks ties when both request.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      gnt0_s = ~ptr_r;
      gnt1_s = ptr_r;
    end else if (req0) begin
      gnt0_s = 1'b1;
    end else if (req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Operand mux; idle cycles feed zeros so the ALU input is deterministic.
  always_comb begin
    alu_a_s   = 8'h00;
    alu_b_s   = 8'h00;
    alu_ctr_s = 4'b0000;
    if (gnt0_s) begin
      alu_a_s   = a0;
      alu_b_s   = b0;
      alu_ctr_s = ctr0;
    end else if (gnt1_s) begin
      alu_a_s   = a1;
      alu_b_s   = b1;
      alu_ctr_s = ctr1;
    end else begin
      alu_a_s   = 8'h00;
      alu_b_s   = 8'h00;
      alu_ctr_s = 4'b0000;
    end
  end

  alu u_alu (
    .ck  (ck),
    .A   (alu_a_s),
    .B   (alu_b_s),
    .CTR (alu_ctr_s),
    .O   (alu_o_s)
  );

  // Pointer moves to the other requester after every grant, holds otherwise.
  always_ff @(posedge ck) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (gnt0_s) begin
      ptr_r <= 1'b1;
    end else if (gnt1_s) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Valid/id pipeline tracking the two ALU register stages.
  always_ff @(posedge ck) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_id_r    <= 1'b0;
    end else begin
      s1_valid_r <= gnt0_s | gnt1_s;
      s1_id_r    <= gnt1_s;
      s2_valid_r <= s1_valid_r;
      s2_id_r    <= s1_id_r;
    end
  end

  // Saturating completion counters.
  always_ff @(posedge ck) begin
    if (rst) begin
      done0_r <= '0;
      done1_r <= '0;
    end else begin
      if (rvalid0 && (done0_r != CNT_MAX)) begin
        done0_r <= done0_r + CNT_ONE;
      end
      if (rvalid1 && (done1_r != CNT_MAX)) begin
        done1_r <= done1_r + CNT_ONE;
      end
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign res     = alu_o_s;
  assign rvalid0 = s2_valid_r & ~s2_id_r & ~rst;
  assign rvalid1 = s2_valid_r &  s2_id_r & ~rst;
  assign done0   = done0_r;
  assign done1   = done1_r;

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: stimulus pushes expected {id,res}, a negedge monitor pops on rvalid.
module tb_alu_arb;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic [7:0] a0 = 8'h00;
  logic [7:0] b0 = 8'h00;
  logic [3:0] ctr0 = 4'h0;
  logic       req1 = 1'b0;
  logic [7:0] a1 = 8'h00;
  logic [7:0] b1 = 8'h00;
  logic [3:0] ctr1 = 4'h0;

  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] res;
  logic [7:0] done0, done1;

  logic       s_gnt0, s_gnt1, s_rvalid0, s_rvalid1;
  logic [7:0] s_res;
  logic [1:0] s_done0, s_done1;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];
  int exp_d0 = 0, exp_d1 = 0, exp_s0 = 0, exp_s1 = 0;

  always #5 ck = ~ck;

  alu_arb dut (
    .ck(ck), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ctr0(ctr0),
    .req1(req1), .a1(a1), .b1(b1), .ctr1(ctr1),
    .gnt0(gnt0), .gnt1(gnt1), .res(res),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1)
  );

  alu_arb #(.CNT_W(2)) dut_sat (
    .ck(ck), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ctr0(ctr0),
    .req1(req1), .a1(a1), .b1(b1), .ctr1(ctr1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .res(s_res),
    .rvalid0(s_rvalid0), .rvalid1(s_rvalid1),
    .done0(s_done0), .done1(s_done1)
  );

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, check combinational grants, record expected result.
  task automatic op(input logic r0, input logic [7:0] xa0, input logic [7:0] xb0, input logic [3:0] xc0,
                    input logic r1, input logic [7:0] xa1, input logic [7:0] xb1, input logic [3:0] xc1,
                    input logic xrst, input logic eg0, input logic eg1, input logic [7:0] eres);
    @(posedge ck);
    #1;
    rst = xrst;
    req0 = r0; a0 = xa0; b0 = xb0; ctr0 = xc0;
    req1 = r1; a1 = xa1; b1 = xb1; ctr1 = xc1;
    if (xrst) sb.delete();
    #3;
    check("gnt0", int'(gnt0), int'(eg0));
    check("gnt1", int'(gnt1), int'(eg1));
    if (eg0) sb.push_back({1'b0, eres});
    if (eg1) sb.push_back({1'b1, eres});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      op(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++)
      op(1'b1, 8'h11, 8'h22, 4'h0, 1'b1, 8'h33, 8'h44, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: result scoreboard plus saturating done-counter model.
  always @(negedge ck) begin
    logic [8:0] e;
    check("done0", int'(done0), exp_d0);
    check("done1", int'(done1), exp_d1);
    check("sat_done0", int'(s_done0), exp_s0);
    check("sat_done1", int'(s_done1), exp_s1);
    if (rvalid0 && rvalid1) begin
      check("rvalid_onehot", 2, 1);
    end else if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", int'({rvalid1, rvalid0}), 0);
      end else begin
        e = sb.pop_front();
        check("rvalid_id", int'(rvalid1), int'(e[8]));
        check("res", int'(res), int'(e[7:0]));
      end
    end
    if (rst) begin
      exp_d0 = 0; exp_d1 = 0; exp_s0 = 0; exp_s1 = 0;
    end else begin
      if (rvalid0) exp_d0 = sat_inc(exp_d0, 255);
      if (rvalid1) exp_d1 = sat_inc(exp_d1, 255);
      if (s_rvalid0) exp_s0 = sat_inc(exp_s0, 3);
      if (s_rvalid1) exp_s1 = sat_inc(exp_s1, 3);
    end
  end

  initial begin
    reset_cycles(2);
    // single add
    op(1'b1, 8'h05, 8'h03, 4'b0000, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h08);
    idle(3);
    // ptr held at 1 across idle: tie goes to requester 1 (NOT 0F)
    op(1'b1, 8'h10, 8'h01, 4'b0001, 1'b1, 8'h0F, 8'h00, 4'b1011, 1'b0, 1'b0, 1'b1, 8'hF0);
    idle(3);
    reset_cycles(1);
    // contention alternates starting at 0
    for (int i = 0; i < 4; i++)
      op(1'b1, 8'h10, 8'h01, 4'b0001, 1'b1, 8'h0F, 8'h00, 4'b1011, 1'b0,
         (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 8'h0F : 8'hF0);
    // rotates and shifts on requester 1
    op(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h81, 8'h00, 4'b1110, 1'b0, 1'b0, 1'b1, 8'hC0);
    op(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h81, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b1, 8'h03);
    op(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h81, 8'h00, 4'b1100, 1'b0, 1'b0, 1'b1, 8'h40);
    op(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h81, 8'h00, 4'b1101, 1'b0, 1'b0, 1'b1, 8'h02);
    // logic ops and wraparound arithmetic on requester 0
    op(1'b1, 8'hF0, 8'h3C, 4'b1000, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h30);
    op(1'b1, 8'hF0, 8'h3C, 4'b1001, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFC);
    op(1'b1, 8'hF0, 8'h3C, 4'b1010, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'hCC);
    op(1'b1, 8'h00, 8'h01, 4'b0001, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFF);
    op(1'b1, 8'hFF, 8'h01, 4'b0000, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    // undefined opcodes return zero
    op(1'b1, 8'hFF, 8'hFF, 4'b0101, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    op(1'b1, 8'h12, 8'h34, 4'b0010, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    op(1'b1, 8'h12, 8'h34, 4'b0111, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    // reset one cycle after a grant discards it; ptr returns to 0
    op(1'b1, 8'h05, 8'h03, 4'b0000, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h08);
    reset_cycles(1);
    op(1'b1, 8'h10, 8'h01, 4'b0001, 1'b1, 8'h0F, 8'h00, 4'b1011, 1'b0, 1'b1, 1'b0, 8'h0F);
    idle(3);
    reset_cycles(1);
    // five back-to-back ops: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++)
      op(1'b1, 8'h01, 8'h01, 4'b0000, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h02);
    idle(4);
    @(negedge ck);
    check("sat_final", int'(s_done0), 3);
    check("done0_final", int'(done0), 5);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: CNT_W, default 8, width of the per-requester completion counters.
REQ-002 ck  input  1  single clock; all state SHALL update on the rising edge of ck.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 operation request; held high with operands stable until gnt0 is seen.
REQ-005 a0, b0  input  8 each  requester 0 operands.
REQ-006 ctr0  input  4  requester 0 ALU opcode (alu CTR encoding).
REQ-007 req1, a1, b1, ctr1  input  1/8/8/4  requester 1 counterparts of REQ-004..006.
REQ-008 gnt0, gnt1  output  1 each  combinational grant; a high gnt in cycle T SHALL mean that request was issued in T.
REQ-009 res  output  8  ALU result, shared by both requesters.
REQ-010 rvalid0, rvalid1  output  1 each  res belongs to requester 0 or 1 in this cycle.
REQ-011 done0, done1  output  CNT_W each  count of results delivered to each requester.

Function
REQ-012 The block SHALL instantiate exactly one alu; its ck is driven by ck, and A, B and CTR are driven from the arbiter mux.
REQ-013 At most one gnt SHALL be high per cycle; gntX SHALL never be high while reqX is low.
REQ-014 Arbitration SHALL be round-robin via 1-bit pointer ptr: if both req, grant requester ptr; if one req, grant it.
REQ-015 After any grant to requester i, ptr SHALL become 1-i on the next edge; with no grant, ptr SHALL hold.
REQ-016 Mux: granted requester's a/b/ctr SHALL drive alu A/B/CTR; with no grant SHALL drive A=0, B=0, CTR=4'b0000.
REQ-017 Valid pipeline: 2-stage shift register of {valid, id}; stage1 <= {grant_any, granted id}, stage2 <= stage1 each edge.
REQ-018 Latency: a grant in cycle T SHALL produce rvalid_id=1 and res=alu result in cycle T+2, exactly one cycle wide.
REQ-019 res SHALL equal the alu O output directly; rvalid0/1 = stage2.valid and stage2.id==0/1.
REQ-020 Throughput SHALL be one operation per cycle; back-to-back grants SHALL yield back-to-back rvalids in grant order.
REQ-021 Opcodes not defined by alu (0010..0111) SHALL be passed through unchanged; result 0 is delivered with rvalid as normal.
REQ-022 doneX SHALL increment by 1 on each cycle rvalidX=1 and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-023 A requester deasserting reqX without a grant SHALL be legal; no state change results.

Reset
REQ-024 While rst=1: gnt0=gnt1=0, ptr=0, both pipeline stages cleared, done0=done1=0.
REQ-025 rvalid0=rvalid1=0 during rst and for the first 2 cycles after rst falls; in-flight operations at reset SHALL be discarded.
REQ-026 alu internal registers are not reset; correctness SHALL rely only on the valid pipeline gating.
REQ-027 Reset asserted mid-stream SHALL take effect at the next edge regardless of req inputs.

Verification
REQ-028 Single op: after reset, req0=1, a0=8'h05, b0=8'h03, ctr0=0000 in cycle T -> gnt0=1 in T; rvalid0=1, res=8'h08 in T+2; done0=1.
REQ-029 Contention: req0=req1=1 every cycle, ctr0=0001 (a0=8'h10,b0=8'h01), ctr1=1011 (a1=8'h0F) -> grants alternate 0,1,0,1 starting with 0; results 8'h0F, 8'hF0 alternating, 2 cycles after each grant.
REQ-030 Rotate/shift: req1 alone, a1=8'h81 with ctr1=1110 then 1111 then 1100 on consecutive grants -> res 8'hC0, 8'h03, 8'h40 on consecutive cycles with rvalid1.
REQ-031 Undefined opcode: req0, ctr0=0101, a0=b0=8'hFF -> rvalid0=1, res=8'h00 two cycles later.
REQ-032 Reset mid-flight: grant in T, rst=1 in T+1 -> no rvalid in T+2..T+3; ptr=0, done0=done1=0 after reset.
REQ-033 Saturation: CNT_W=2, 5 consecutive requester-0 ops -> done0 reads 1,2,3,3,3.
